// File: rtl/bn_param_sequencer.sv
// Batch-norm parameter sequencer: loads DEPTH channels of {gamma, beta, moving_mean,
// denominator} from a word stream, then presents them one channel at a time on request.
module bn_param_sequencer #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4
) (
    input  logic                                         clk,
    input  logic                                         rst,
    input  logic [DATA_WIDTH-1:0]                        param_i,
    input  logic                                         param_valid_i,
    output logic                                         param_ready_o,
    input  logic                                         start_i,
    input  logic                                         clear_i,
    output logic [DATA_WIDTH-1:0]                        gamma_o,
    output logic [DATA_WIDTH-1:0]                        beta_o,
    output logic [DATA_WIDTH-1:0]                        moving_mean_o,
    output logic [DATA_WIDTH-1:0]                        denominator_o,
    output logic [((DEPTH > 1) ? $clog2(DEPTH) : 1)-1:0] ch_o,
    output logic                                         ch_valid_o,
    input  logic                                         ch_ready_i,
    output logic                                         loaded_o,
    output logic                                         done_o
);

    localparam int CW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW-1:0] LAST_CH = CW'(DEPTH - 1);

    typedef enum logic [1:0] {
        LOAD,
        READY,
        RUN,
        DONE
    } state_t;

    state_t              state;
    state_t              state_n;
    logic [CW-1:0]       ch_cnt;
    logic [CW-1:0]       ch_n;
    logic [1:0]          word_cnt;
    logic [1:0]          word_n;
    logic                wr_en;
    logic [DATA_WIDTH-1:0] bank [DEPTH][4];

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= LOAD;
            ch_cnt   <= '0;
            word_cnt <= '0;
        end else begin
            state    <= state_n;
            ch_cnt   <= ch_n;
            word_cnt <= word_n;
        end
    end

    // The bank has no reset: contents survive rst and clear, and are only overwritten by a reload.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            bank[ch_cnt][word_cnt] <= param_i;
        end
    end

    always_comb begin
        state_n = state;
        ch_n    = ch_cnt;
        word_n  = word_cnt;
        wr_en   = 1'b0;
        case (state)
            LOAD: begin
                if (param_valid_i) begin
                    wr_en = !rst;
                    if (word_cnt == 2'd3) begin
                        word_n = 2'd0;
                        if (ch_cnt == LAST_CH) begin
                            ch_n    = '0;
                            state_n = READY;
                        end else begin
                            ch_n = ch_cnt + CW'(1);
                        end
                    end else begin
                        word_n = word_cnt + 2'd1;
                    end
                end
            end
            READY: begin
                // clear has priority over a simultaneous start
                if (clear_i) begin
                    state_n = LOAD;
                    ch_n    = '0;
                    word_n  = 2'd0;
                end else if (start_i) begin
                    state_n = RUN;
                    ch_n    = '0;
                end
            end
            RUN: begin
                if (ch_ready_i) begin
                    if (ch_cnt == LAST_CH) begin
                        state_n = DONE;
                    end else begin
                        ch_n = ch_cnt + CW'(1);
                    end
                end
            end
            DONE: begin
                state_n = READY;
                ch_n    = '0;
            end
            default: begin
                state_n = LOAD;
                ch_n    = '0;
                word_n  = 2'd0;
            end
        endcase
    end

    assign param_ready_o = (state == LOAD);
    assign loaded_o      = (state != LOAD);
    assign ch_valid_o    = (state == RUN);
    assign done_o        = (state == DONE);
    assign ch_o          = ch_cnt;

    assign gamma_o       = bank[ch_cnt][0];
    assign beta_o        = bank[ch_cnt][1];
    assign moving_mean_o = bank[ch_cnt][2];
    assign denominator_o = bank[ch_cnt][3];

endmodule

// File: tb/tb_bn_param_sequencer.sv
// Self-checking bench for bn_param_sequencer with DEPTH=2: directed scenarios plus
// randomized loads/sweeps checked against a word-list reference model.
module tb_bn_param_sequencer;

    localparam int DW = 32;
    localparam int DEPTH = 2;
    localparam int NWORDS = DEPTH * 4;

    localparam logic [3:0] S_LOAD  = 4'b1000;
    localparam logic [3:0] S_READY = 4'b0100;
    localparam logic [2:0] R_RUN   = 3'b010;
    localparam logic [2:0] R_DONE  = 3'b001;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [DW-1:0] param_i = '0;
    logic          param_valid_i = 1'b0;
    logic          param_ready_o;
    logic          start_i = 1'b0;
    logic          clear_i = 1'b0;
    logic [DW-1:0] gamma_o, beta_o, moving_mean_o, denominator_o;
    logic [0:0]    ch_o;
    logic          ch_valid_o;
    logic          ch_ready_i = 1'b0;
    logic          loaded_o;
    logic          done_o;

    int errors = 0;
    int checks = 0;

    logic [DW-1:0] model [NWORDS];

    bn_param_sequencer #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .param_i(param_i), .param_valid_i(param_valid_i), .param_ready_o(param_ready_o),
        .start_i(start_i), .clear_i(clear_i),
        .gamma_o(gamma_o), .beta_o(beta_o), .moving_mean_o(moving_mean_o),
        .denominator_o(denominator_o),
        .ch_o(ch_o), .ch_valid_o(ch_valid_o), .ch_ready_i(ch_ready_i),
        .loaded_o(loaded_o), .done_o(done_o)
    );

    always #5 clk = ~clk;

    // Outputs are sampled 1 time unit after each rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] stat();
        return {param_ready_o, loaded_o, ch_valid_o, done_o};
    endfunction

    function automatic logic [2:0] rstat();
        return {param_ready_o, ch_valid_o, done_o};
    endfunction

    function automatic logic [4*DW-1:0] exp_params(input int ch);
        return {model[ch*4], model[ch*4+1], model[ch*4+2], model[ch*4+3]};
    endfunction

    task automatic do_reset();
        rst = 1'b1; start_i = 1'b0; clear_i = 1'b0; ch_ready_i = 1'b0; param_valid_i = 1'b0;
        step();
        rst = 1'b0;
    endtask

    task automatic fill_model_seq(input logic [DW-1:0] base);
        for (int k = 0; k < NWORDS; k++) model[k] = base + DW'(k);
    endtask

    task automatic fill_model_rand();
        for (int k = 0; k < NWORDS; k++) model[k] = $urandom;
    endtask

    // Streams the model words; gap_len idle cycles precede word index gap_at.
    task automatic load_model(input int gap_at, input int gap_len, input bit rand_gaps);
        int n;
        for (int k = 0; k < NWORDS; k++) begin
            n = (k == gap_at) ? gap_len : 0;
            if (rand_gaps) n += int'($urandom_range(0, 2));
            for (int g = 0; g < n; g++) begin
                param_valid_i = 1'b0;
                param_i = $urandom;
                step();
                checks++;
                if (stat() !== S_LOAD) begin
                    errors++;
                    $display("[TB] FAIL load_gap word=%0d status=%b expected=%b", k, stat(), S_LOAD);
                end
            end
            param_valid_i = 1'b1;
            param_i = model[k];
            step();
            checks++;
            if (stat() !== ((k == NWORDS - 1) ? S_READY : S_LOAD)) begin
                errors++;
                $display("[TB] FAIL load_word word=%0d status=%b expected=%b", k, stat(),
                         (k == NWORDS - 1) ? S_READY : S_LOAD);
            end
        end
        param_valid_i = 1'b0;
    endtask

    // One sweep from READY; rand_ready inserts random consumer stalls.
    task automatic sweep_model(input bit rand_ready, input string tag);
        int exp_ch = 0;
        int cycles = 0;
        logic rdy;
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        while (1) begin
            checks++;
            if (rstat() !== R_RUN || ch_o !== 1'(exp_ch)) begin
                errors++;
                $display("[TB] FAIL %s_run status=%b ch=%0d expected status=%b ch=%0d",
                         tag, rstat(), ch_o, R_RUN, exp_ch);
            end
            checks++;
            if ({gamma_o, beta_o, moving_mean_o, denominator_o} !== exp_params(exp_ch)) begin
                errors++;
                $display("[TB] FAIL %s_params ch=%0d got=%h expected=%h", tag, exp_ch,
                         {gamma_o, beta_o, moving_mean_o, denominator_o}, exp_params(exp_ch));
            end
            rdy = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            ch_ready_i = rdy;
            step();
            cycles++;
            if (rdy) begin
                if (exp_ch == DEPTH - 1) break;
                exp_ch++;
            end
            if (cycles > 60) begin
                errors++;
                $display("[TB] FAIL %s_timeout sweep did not end within 60 cycles", tag);
                break;
            end
        end
        ch_ready_i = 1'b0;
        checks++;
        if (rstat() !== R_DONE) begin
            errors++;
            $display("[TB] FAIL %s_done status=%b expected=%b", tag, rstat(), R_DONE);
        end
        step();
        checks++;
        if (stat() !== S_READY) begin
            errors++;
            $display("[TB] FAIL %s_ready status=%b expected=%b", tag, stat(), S_READY);
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (stat() !== S_LOAD || ch_o !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset status=%b ch=%0d expected status=%b ch=0", stat(), ch_o, S_LOAD);
        end
    endtask

    task automatic test_load_basic();
        fill_model_seq(32'h01);
        load_model(-1, 0, 1'b0);
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        checks++;
        if (rstat() !== R_RUN || ch_o !== 1'b0 ||
            {gamma_o, beta_o, moving_mean_o, denominator_o} !== {32'h1, 32'h2, 32'h3, 32'h4}) begin
            errors++;
            $display("[TB] FAIL first_ch status=%b ch=%0d params=%h expected ch0=01/02/03/04",
                     rstat(), ch_o, {gamma_o, beta_o, moving_mean_o, denominator_o});
        end
    endtask

    // Continues from RUN at ch0 left by test_load_basic.
    task automatic test_hold_sweep();
        int done_cnt = 0;
        ch_ready_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            checks++;
            if (rstat() !== R_RUN || ch_o !== 1'b0 ||
                {gamma_o, beta_o, moving_mean_o, denominator_o} !== {32'h1, 32'h2, 32'h3, 32'h4}) begin
                errors++;
                $display("[TB] FAIL hold cycle=%0d status=%b ch=%0d params=%h", i, rstat(), ch_o,
                         {gamma_o, beta_o, moving_mean_o, denominator_o});
            end
        end
        ch_ready_i = 1'b1;
        step();
        checks++;
        if (rstat() !== R_RUN || ch_o !== 1'b1 ||
            {gamma_o, beta_o, moving_mean_o, denominator_o} !== {32'h5, 32'h6, 32'h7, 32'h8}) begin
            errors++;
            $display("[TB] FAIL second_ch status=%b ch=%0d params=%h expected ch1=05/06/07/08",
                     rstat(), ch_o, {gamma_o, beta_o, moving_mean_o, denominator_o});
        end
        step();
        ch_ready_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (done_o === 1'b1) done_cnt++;
            if (i > 0) begin
                checks++;
                if (stat() !== S_READY) begin
                    errors++;
                    $display("[TB] FAIL after_done cycle=%0d status=%b expected=%b", i, stat(), S_READY);
                end
            end
            step();
        end
        checks++;
        if (done_cnt != 1) begin
            errors++;
            $display("[TB] FAIL done_pulse count=%0d expected=1", done_cnt);
        end
    endtask

    task automatic test_gap();
        do_reset();
        fill_model_seq(32'h01);
        load_model(3, 3, 1'b0);
        sweep_model(1'b0, "gap");
    endtask

    task automatic test_back_to_back();
        sweep_model(1'b0, "b2b");
        sweep_model(1'b1, "b2b_stall");
    endtask

    task automatic test_start_clear();
        start_i = 1'b1;
        clear_i = 1'b1;
        step();
        start_i = 1'b0;
        clear_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (stat() !== S_LOAD) begin
                errors++;
                $display("[TB] FAIL start_clear cycle=%0d status=%b expected=%b", i, stat(), S_LOAD);
            end
            step();
        end
        fill_model_seq(32'h11);
        load_model(-1, 0, 1'b0);
        sweep_model(1'b0, "reload");
    endtask

    task automatic test_rst_mid();
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        ch_ready_i = 1'b1;
        step();
        ch_ready_i = 1'b0;
        checks++;
        if (rstat() !== R_RUN || ch_o !== 1'b1) begin
            errors++;
            $display("[TB] FAIL pre_rst status=%b ch=%0d expected status=%b ch=1", rstat(), ch_o, R_RUN);
        end
        rst = 1'b1;
        ch_ready_i = 1'b1;
        step();
        rst = 1'b0;
        ch_ready_i = 1'b0;
        checks++;
        if (stat() !== S_LOAD || ch_o !== 1'b0) begin
            errors++;
            $display("[TB] FAIL rst_mid_run status=%b ch=%0d expected status=%b ch=0", stat(), ch_o, S_LOAD);
        end
        // Partial load then reset: the full set must be reloaded from word 0.
        param_valid_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            param_i = $urandom;
            step();
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        param_valid_i = 1'b0;
        fill_model_rand();
        load_model(-1, 0, 1'b0);
        sweep_model(1'b0, "rst_mid_load");
    endtask

    task automatic test_ignore();
        param_valid_i = 1'b1;
        param_i = $urandom;
        ch_ready_i = 1'b1;
        step();
        param_valid_i = 1'b0;
        ch_ready_i = 1'b0;
        checks++;
        if (stat() !== S_READY) begin
            errors++;
            $display("[TB] FAIL ignore_ready status=%b expected=%b", stat(), S_READY);
        end
        do_reset();
        start_i = 1'b1;
        ch_ready_i = 1'b1;
        step();
        start_i = 1'b0;
        ch_ready_i = 1'b0;
        checks++;
        if (stat() !== S_LOAD) begin
            errors++;
            $display("[TB] FAIL ignore_load status=%b expected=%b", stat(), S_LOAD);
        end
        fill_model_rand();
        load_model(-1, 0, 1'b0);
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        clear_i = 1'b1;
        start_i = 1'b1;
        step();
        clear_i = 1'b0;
        start_i = 1'b0;
        checks++;
        if (rstat() !== R_RUN || ch_o !== 1'b0 ||
            {gamma_o, beta_o, moving_mean_o, denominator_o} !== exp_params(0)) begin
            errors++;
            $display("[TB] FAIL ignore_run status=%b ch=%0d params=%h expected=%h", rstat(), ch_o,
                     {gamma_o, beta_o, moving_mean_o, denominator_o}, exp_params(0));
        end
        ch_ready_i = 1'b1;
        step();
        step();
        ch_ready_i = 1'b0;
        step();
        checks++;
        if (stat() !== S_READY) begin
            errors++;
            $display("[TB] FAIL ignore_end status=%b expected=%b", stat(), S_READY);
        end
    endtask

    task automatic test_random();
        for (int r = 0; r < 6; r++) begin
            if (r % 2 == 0) do_reset();
            else begin
                clear_i = 1'b1;
                step();
                clear_i = 1'b0;
            end
            fill_model_rand();
            load_model(-1, 0, 1'b1);
            sweep_model(1'b1, "rand");
        end
    endtask

    initial begin
        test_reset();
        test_load_basic();
        test_hold_sweep();
        test_gap();
        test_back_to_back();
        test_start_clear();
        test_rst_mid();
        test_ignore();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
